// File: rtl/memory_arbiter.sv
// Two-core memory arbiter: one RAM transaction at a time, data before
// instruction, round-robin ties, one-cycle snoop ahead of coherent writes.
module memory_arbiter #(
  parameter int CPUS = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [CPUS-1:0]       iREN,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  logic [CPUS-1:0][31:0] iaddr,
  input  logic [CPUS-1:0][31:0] daddr,
  input  logic [CPUS-1:0][31:0] dstore,
  input  logic [CPUS-1:0]       ccwrite,
  input  logic [CPUS-1:0]       cctrans,
  input  logic [31:0]           ramload,
  input  logic [1:0]            ramstate,
  output logic [CPUS-1:0]       iwait,
  output logic [CPUS-1:0]       dwait,
  output logic [CPUS-1:0][31:0] iload,
  output logic [CPUS-1:0][31:0] dload,
  output logic [31:0]           ramaddr,
  output logic [31:0]           ramstore,
  output logic                  ramREN,
  output logic                  ramWEN,
  output logic [CPUS-1:0]       ccwait,
  output logic [CPUS-1:0]       ccinv,
  output logic [CPUS-1:0][31:0] ccsnoopaddr
);

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    DREAD,
    DWRITE,
    IREAD
  } state_t;

  localparam logic [1:0] ACCESS = 2'd2;

  state_t state, nstate;
  logic   g, ng;
  logic   last, nlast;
  logic   o;
  logic   acc;
  logic [CPUS-1:0] dreq;

  assign o    = ~g;
  assign acc  = (ramstate == ACCESS);
  assign dreq = dREN | dWEN;

  for (genvar k = 0; k < CPUS; k++) begin : g_load
    assign iload[k] = ramload;
    assign dload[k] = ramload;
  end

  // Tie goes to the core that did not complete last.
  function automatic logic pick(input logic [1:0] m, input logic l);
    return (m == 2'b11) ? ~l : m[1];
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      g     <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= nstate;
      g     <= ng;
      last  <= nlast;
    end
  end

  always_comb begin
    nstate      = state;
    ng          = g;
    nlast       = last;
    iwait       = '1;
    dwait       = '1;
    ramaddr     = '0;
    ramstore    = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    unique case (state)
      IDLE: begin
        if (|dreq) begin
          ng = pick(dreq, last);
          if (cctrans[ng] && ccwrite[ng])
            nstate = SNOOP;
          else if (dWEN[ng])
            nstate = DWRITE;
          else
            nstate = DREAD;
        end else if (|iREN) begin
          ng     = pick(iREN, last);
          nstate = IREAD;
        end
      end
      SNOOP: begin
        ccwait[o]      = 1'b1;
        ccinv[o]       = 1'b1;
        ccsnoopaddr[o] = daddr[g];
        nstate = dWEN[g] ? DWRITE : DREAD;
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = daddr[g];
        if (!dREN[g]) begin
          nstate = IDLE;
        end else if (acc) begin
          dwait[g] = 1'b0;
          nstate   = IDLE;
          nlast    = g;
        end
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[g];
        ramstore = dstore[g];
        if (!dWEN[g]) begin
          nstate = IDLE;
        end else if (acc) begin
          dwait[g] = 1'b0;
          nstate   = IDLE;
          nlast    = g;
        end
      end
      IREAD: begin
        ramREN  = 1'b1;
        ramaddr = iaddr[g];
        if (!iREN[g]) begin
          nstate = IDLE;
        end else if (acc) begin
          iwait[g] = 1'b0;
          nstate   = IDLE;
          nlast    = g;
        end
      end
      default: nstate = IDLE;
    endcase
  end

endmodule
